// File: rtl/serial_frame_demux.sv
// serial_frame_demux: start-bit framed serial receiver that forwards a sized payload to one of 2**CH_BITS channels; define PARITY_EN to add an even-parity bit
module serial_frame_demux #(
  parameter int CH_BITS  = 2,
  parameter int LEN_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Clk_EN,
  input  logic                  serIn,
  output logic                  serOut,
  output logic                  serOutValid,
  output logic [LEN_BITS-1:0]   cnt_out,
  output logic [CH_BITS-1:0]    chan,
  output logic [2**CH_BITS-1:0] chanOneHot,
  output logic                  frameDone,
  output logic                  parityErr
);
  localparam int NC = 2**CH_BITS;
  localparam int MB = CH_BITS > LEN_BITS ? CH_BITS : LEN_BITS;
  localparam int BW = $clog2(MB + 1);
  localparam logic [NC-1:0] ONE = 1;
  typedef enum logic [2:0] {IDLE, CHAN, LEN, DATA, PAR} state_t;
`ifdef PARITY_EN
  localparam state_t TAIL = PAR;
`else
  localparam state_t TAIL = IDLE;
`endif
  state_t state_q, state_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [CH_BITS-1:0] csh_q, csh_d, chan_q, chan_d;
  logic [LEN_BITS-1:0] lsh_q, lsh_d, cnt_q, cnt_d;
  logic par_q, par_d, done_q, done_d, perr_q, perr_d;
  // state and datapath registers; done/perr update every clk so pulses stay one cycle wide
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      csh_q   <= '0;
      chan_q  <= '0;
      lsh_q   <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      csh_q   <= csh_d;
      chan_q  <= chan_d;
      lsh_q   <= lsh_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
    end
  end
  // next-state: field capture, payload countdown, parity accumulation
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    csh_d   = csh_q;
    chan_d  = chan_q;
    lsh_d   = lsh_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    done_d  = 1'b0;
    perr_d  = 1'b0;
    if (Clk_EN) begin
      case (state_q)
        IDLE: if (!serIn) begin
          state_d = CHAN;
          bcnt_d  = '0;
          par_d   = 1'b0;
        end
        CHAN: begin
          csh_d  = CH_BITS'({csh_q, serIn});
          par_d  = par_q ^ serIn;
          bcnt_d = bcnt_q + 1'b1;
          if (bcnt_q == BW'(CH_BITS - 1)) begin
            state_d = LEN;
            chan_d  = csh_d;
            bcnt_d  = '0;
          end
        end
        LEN: begin
          lsh_d  = LEN_BITS'({lsh_q, serIn});
          par_d  = par_q ^ serIn;
          bcnt_d = bcnt_q + 1'b1;
          if (bcnt_q == BW'(LEN_BITS - 1)) begin
            bcnt_d  = '0;
            cnt_d   = lsh_d;
            state_d = lsh_d != '0 ? DATA : TAIL;
            done_d  = lsh_d == '0 && TAIL == IDLE;
          end
        end
        DATA: begin
          cnt_d = cnt_q - 1'b1;
          par_d = par_q ^ serIn;
          if (cnt_q == LEN_BITS'(1)) begin
            state_d = TAIL;
            done_d  = TAIL == IDLE;
          end
        end
`ifdef PARITY_EN
        PAR: begin
          state_d = IDLE;
          done_d  = 1'b1;
          perr_d  = par_q ^ serIn;
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end
  // outputs: payload path is combinational from serIn, strobes are registered
  always_comb begin
    serOutValid = state_q == DATA && Clk_EN;
    serOut      = serIn & serOutValid;
    cnt_out     = cnt_q;
    chan        = chan_q;
    chanOneHot  = serOutValid ? ONE << chan_q : '0;
    frameDone   = done_q;
    parityErr   = perr_q;
  end
endmodule

// File: tb/tb_serial_frame_demux.sv
// tb_serial_frame_demux: frame-level reference model driving directed and random frames
module tb_serial_frame_demux;
  localparam int CB = 2, LB = 4;
`ifdef PARITY_EN
  localparam int PE = 1;
`else
  localparam int PE = 0;
`endif
  logic clk = 0, rst = 1, Clk_EN = 0, serIn = 0;
  logic serOut, serOutValid, frameDone, parityErr;
  logic [LB-1:0] cnt_out;
  logic [CB-1:0] chan;
  logic [2**CB-1:0] chanOneHot;
  int npass = 0, ntot = 0, m_chan = 0;
  logic pend_done = 0, pend_perr = 0;
  serial_frame_demux #(.CH_BITS(CB), .LEN_BITS(LB)) dut (
    .clk(clk), .rst(rst), .Clk_EN(Clk_EN), .serIn(serIn), .serOut(serOut),
    .serOutValid(serOutValid), .cnt_out(cnt_out), .chan(chan),
    .chanOneHot(chanOneHot), .frameDone(frameDone), .parityErr(parityErr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    assert (got === exp) npass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick(input logic en, b, dv, input int rem, input logic fin, pe);
    @(negedge clk);
    rst = 0;
    Clk_EN = en;
    serIn = b;
    #1;
    chk("serOutValid", serOutValid, dv & en);
    chk("serOut", serOut, dv & en & b);
    chk("cnt_out", cnt_out, dv ? rem : 0);
    chk("chanOneHot", chanOneHot, (dv & en) ? 1 << m_chan : 0);
    chk("chan", chan, m_chan);
    chk("frameDone", frameDone, pend_done);
    chk("parityErr", parityErr, pend_perr);
    pend_done = en & fin;
    pend_perr = en & fin & pe;
  endtask
  task automatic send(input int ch, input int len, input logic [15:0] d, input int gap, input logic bad, input int stop);
    int n, hdr;
    logic p, b, dv;
    hdr = 1 + CB + LB;
    n = hdr + len + PE;
    p = 0;
    for (int k = 0; k < CB; k++) p ^= ch[k];
    for (int k = 0; k < LB; k++) p ^= len[k];
    for (int k = 0; k < len; k++) p ^= d[k];
    for (int i = 0; i < n && i < stop; i++) begin
      b = i == 0 ? 1'b0 : i <= CB ? ch[CB-i] : i < hdr ? len[hdr-1-i] : i < hdr + len ? d[i-hdr] : p ^ bad;
      dv = i >= hdr && i < hdr + len;
      if (gap == 1 || (gap == 2 && $urandom_range(1) == 1)) tick(0, b, dv, len - (i - hdr), 0, 0);
      tick(1, b, dv, len - (i - hdr), i == n - 1, bad);
      if (i == CB) m_chan = ch;
    end
  endtask
  initial begin
    rst = 1;
    Clk_EN = 1;
    repeat (2) @(negedge clk) serIn = ~serIn;
    tick(1, 1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    tick(1, 1, 0, 0, 0, 0);
    send(2, 3, 16'h5, 0, 0, 99);
    tick(1, 1, 0, 0, 0, 0);
    send(3, 0, 16'h0, 0, 0, 99);
    tick(1, 1, 0, 0, 0, 0);
    send(1, 15, 16'($urandom), 0, 0, 99);
    send(2, 5, 16'($urandom), 0, 0, 99);
    send(0, 15, 16'h7fff, 0, 0, 99);
    send(2, 3, 16'h5, 1, 0, 99);
    tick(1, 1, 0, 0, 0, 0);
`ifdef PARITY_EN
    send(2, 3, 16'h5, 0, 0, 99);
    send(2, 3, 16'h5, 0, 1, 99);
    send(3, 0, 16'h0, 0, 1, 99);
`endif
    for (int f = 0; f < 25; f++) begin
      send($urandom_range(3), $urandom_range(15), 16'($urandom), $urandom_range(2), PE != 0 && $urandom_range(1) == 1, 99);
      repeat ($urandom_range(2)) tick($urandom_range(1) == 1, 1, 0, 0, 0, 0);
    end
    send(3, 8, 16'($urandom), 0, 0, 1 + CB + LB + 3);
    @(negedge clk);
    rst = 1;
    Clk_EN = 1;
    serIn = 1;
    m_chan = 0;
    pend_done = 0;
    pend_perr = 0;
    tick(1, 1, 0, 0, 0, 0);
    tick(1, 1, 0, 0, 0, 0);
    send(1, 2, 16'h2, 0, 0, 99);
    tick(1, 1, 0, 0, 0, 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
